ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT, 2000000, max iClk cycles a prefix state may wait for its next byte before abandoning the sequence (1 to 2^21-1).
REQ-002 iClk  input  1  system clock; all state updates on its rising edge.
REQ-003 iReset  input  1  asynchronous, active-high reset.
REQ-004 iFlag  input  1  byte-ready strobe from the PS/2 receiver; each rising edge marks one new byte.
REQ-005 iData  input  8  scan-code byte from the PS/2 receiver; valid while iFlag is high.
REQ-006 oValid  output  1  one-cycle pulse marking one completed key event.
REQ-007 oMake  output  1  event type: 1 = press (make), 0 = release (break); valid with oValid.
REQ-008 oExt  output  1  event carried the E0 prefix; valid with oValid.
REQ-009 oCode  output  8  final scan code of the event; valid with oValid.
REQ-010 oKeys  output  13  held-note bitmap; bit i set while note i is held.
REQ-011 oNote  output  4  index of the lowest set bit of oKeys; 0 when oKeys is 0.
REQ-012 oNoteValid  output  1  OR-reduction of oKeys.

Function
REQ-013 The block SHALL register iFlag and accept a byte only when iFlag is 1 and its registered value is 0; a strobe held high for several cycles SHALL count as one byte.
REQ-014 The FSM SHALL have exactly 4 states: IDLE, BRK (F0 seen), EXT (E0 seen) and EXT_BRK (E0 F0 seen).
REQ-015 Byte E0, accepted in any state, SHALL move the FSM to EXT and restart the timeout counter.
REQ-016 Byte F0 SHALL move IDLE to BRK and EXT to EXT_BRK; in BRK or EXT_BRK it SHALL keep the state and restart the timeout counter.
REQ-017 In IDLE, bytes 00, AA, E1, EE, FA, FE and FF SHALL be discarded with no event and no state change.
REQ-018 Any other byte SHALL complete an event: oMake = 0 in BRK/EXT_BRK and 1 otherwise; oExt = 1 in EXT/EXT_BRK and 0 otherwise; oCode = the byte; the FSM then returns to IDLE.
REQ-019 oValid SHALL be high for exactly one cycle, on the cycle after the edge at which the completing byte is accepted, and SHALL be 0 in every other cycle.
REQ-020 oMake, oExt and oCode SHALL hold their last event values between events.
REQ-021 The note map SHALL apply to non-extended codes only, as note index to code:
  - 0 = 1C, 1 = 1D, 2 = 1B, 3 = 24, 4 = 23, 5 = 2B, 6 = 2C
  - 7 = 34, 8 = 35, 9 = 33, 10 = 3C, 11 = 3B, 12 = 42
REQ-022 A mapped make SHALL set its oKeys bit and a mapped break SHALL clear it, at the same edge that raises oValid.
REQ-023 Unmapped codes and extended events SHALL raise oValid but leave oKeys unchanged.
REQ-024 A repeated make of a held key (typematic) SHALL raise oValid and leave oKeys unchanged.
REQ-025 A break of a key that is not held SHALL raise oValid and leave oKeys unchanged.
REQ-026 While the FSM is in BRK, EXT or EXT_BRK, a counter SHALL increment every cycle that no byte is accepted.
REQ-027 When that counter reaches TIMEOUT, the FSM SHALL return to IDLE with no event.
REQ-028 The counter SHALL be zeroed on entry to IDLE.
REQ-029 oNote and oNoteValid SHALL be combinational from the oKeys register, so they change on the same edge as oKeys.

Reset
REQ-030 While iReset is high, the FSM SHALL be in IDLE, and the timeout counter, registered iFlag, oValid, oMake, oExt, oCode and oKeys SHALL all be 0, regardless of the clock.
REQ-031 Reset asserted partway through a prefix sequence SHALL discard that sequence.
REQ-032 The first byte after reset is released SHALL be decoded from IDLE.

Verification
REQ-033 Bytes 1C then F0,1C (one-cycle strobes) -> oValid/oMake = 1/1 with oKeys = 0x0001, then 1/0 with oKeys = 0; oNote = 0 throughout.
REQ-034 Make 23 then make 42 -> oKeys = 0x1010, oNote = 4; then F0,23 -> oKeys = 0x1000, oNote = 12, oNoteValid = 1.
REQ-035 Bytes E0,F0,75 -> a single event with oExt = 1, oMake = 0, oCode = 75; oKeys unchanged.
REQ-036 Byte F0, then idle for TIMEOUT cycles, then 1C -> no event from F0; 1C is reported as a make and sets oKeys bit 0.
REQ-037 iFlag held high for 5 cycles with byte 1B; byte AA in IDLE -> exactly one make event for 1B and no event for AA.
REQ-038 iReset pulsed between E0 and F0, then byte 1C -> 1C is reported as a non-extended make and sets oKeys = 0x0001.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into make/break key events
// and keeps a held-note bitmap for the 13 keys of a one-octave keyboard.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iFlag,
  input  logic [7:0]  iData,
  output logic        oValid,
  output logic        oMake,
  output logic        oExt,
  output logic [7:0]  oCode,
  output logic [12:0] oKeys,
  output logic [3:0]  oNote,
  output logic        oNoteValid
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT - 1);

  state_t      r_state, w_nextState;
  logic [20:0] r_cnt, w_nextCnt;
  logic        r_flag;
  logic        r_valid, r_make, r_ext;
  logic [7:0]  r_code;
  logic [12:0] r_keys;

  logic        w_accept;
  logic        w_event, w_eventMake, w_eventExt;
  logic        w_discard;
  logic        w_noteHit;
  logic [3:0]  w_noteIdx;
  logic [3:0]  w_lowest;

  assign w_accept = iFlag & ~r_flag;

  always_comb begin
    w_discard = 1'b0;
    case (iData)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_discard = 1'b1;
      default: w_discard = 1'b0;
    endcase
  end

  always_comb begin
    w_noteHit = 1'b1;
    w_noteIdx = 4'd0;
    case (iData)
      8'h1C: w_noteIdx = 4'd0;
      8'h1D: w_noteIdx = 4'd1;
      8'h1B: w_noteIdx = 4'd2;
      8'h24: w_noteIdx = 4'd3;
      8'h23: w_noteIdx = 4'd4;
      8'h2B: w_noteIdx = 4'd5;
      8'h2C: w_noteIdx = 4'd6;
      8'h34: w_noteIdx = 4'd7;
      8'h35: w_noteIdx = 4'd8;
      8'h33: w_noteIdx = 4'd9;
      8'h3C: w_noteIdx = 4'd10;
      8'h3B: w_noteIdx = 4'd11;
      8'h42: w_noteIdx = 4'd12;
      default: w_noteHit = 1'b0;
    endcase
  end

  // Any accepted byte restarts the prefix timer; an abandoned prefix falls back to IDLE.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_event     = 1'b0;
    w_eventMake = (r_state != BRK) && (r_state != EXT_BRK);
    w_eventExt  = (r_state == EXT) || (r_state == EXT_BRK);
    if (w_accept) begin
      w_nextCnt = '0;
      if (iData == 8'hE0) begin
        w_nextState = EXT;
      end else if (iData == 8'hF0) begin
        case (r_state)
          IDLE:    w_nextState = BRK;
          EXT:     w_nextState = EXT_BRK;
          default: w_nextState = r_state;
        endcase
      end else if (!(r_state == IDLE && w_discard)) begin
        w_event     = 1'b1;
        w_nextState = IDLE;
      end
    end else if (r_state != IDLE) begin
      if (r_cnt == TIMEOUT_LAST) begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end else begin
        w_nextCnt = r_cnt + 21'd1;
      end
    end else begin
      w_nextCnt = '0;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_flag  <= iFlag;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_valid <= 1'b0;
      r_make  <= 1'b0;
      r_ext   <= 1'b0;
      r_code  <= '0;
      r_keys  <= '0;
    end else begin
      r_valid <= w_event;
      if (w_event) begin
        r_make <= w_eventMake;
        r_ext  <= w_eventExt;
        r_code <= iData;
        if (!w_eventExt && w_noteHit) begin
          r_keys[w_noteIdx] <= w_eventMake;
        end
      end
    end
  end

  // Scan from the top so the lowest held note wins.
  always_comb begin
    w_lowest = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (r_keys[i]) w_lowest = 4'(i);
    end
  end

  assign oValid     = r_valid;
  assign oMake      = r_make;
  assign oExt       = r_ext;
  assign oCode      = r_code;
  assign oKeys      = r_keys;
  assign oNote      = w_lowest;
  assign oNoteValid = |r_keys;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a byte-level model queues expected
// events, and a negedge monitor compares each oValid pulse against the queue.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 40;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iFlag;
  logic [7:0]  iData;
  logic        oValid, oMake, oExt, oNoteValid;
  logic [7:0]  oCode;
  logic [12:0] oKeys;
  logic [3:0]  oNote;

  ps2_key_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .iClk(iClk), .iReset(iReset), .iFlag(iFlag), .iData(iData),
    .oValid(oValid), .oMake(oMake), .oExt(oExt), .oCode(oCode),
    .oKeys(oKeys), .oNote(oNote), .oNoteValid(oNoteValid)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic        make;
    logic        ext;
    logic [7:0]  code;
    logic [12:0] keys;
  } exp_t;

  exp_t        expQ[$];
  exp_t        popped;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          mBrk, mExt;
  logic [12:0] mKeys;
  int          lastAccept = 0;

  logic [7:0] noteCodes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  logic [7:0] discardCodes [7] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  always @(posedge iClk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int lowestNote(input logic [12:0] k);
    for (int i = 0; i < 13; i++) if (k[i]) return i;
    return 0;
  endfunction

  function automatic bit isDiscard(input logic [7:0] b);
    foreach (discardCodes[i]) if (discardCodes[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: prefixes are plain flags, a long silence forgets them.
  task automatic modelByte(input logic [7:0] b, input int acc);
    int idx;
    exp_t e;
    if ((mBrk || mExt) && (acc - lastAccept - 1 >= TIMEOUT)) begin
      mBrk = 1'b0;
      mExt = 1'b0;
    end
    lastAccept = acc;
    if (b == 8'hE0) begin
      mExt = 1'b1;
      mBrk = 1'b0;
    end else if (b == 8'hF0) begin
      mBrk = 1'b1;
    end else if (!mBrk && !mExt && isDiscard(b)) begin
      // silently dropped
    end else begin
      idx = -1;
      foreach (noteCodes[i]) if (noteCodes[i] == b) idx = i;
      if (!mExt && idx >= 0) mKeys[idx] = !mBrk;
      e.make = !mBrk;
      e.ext  = mExt;
      e.code = b;
      e.keys = mKeys;
      expQ.push_back(e);
      mBrk = 1'b0;
      mExt = 1'b0;
    end
  endtask

  // Called at a negedge; the byte is accepted at the next posedge.
  task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
    iData = b;
    iFlag = 1'b1;
    modelByte(b, cyc + 1);
    repeat (hold) @(negedge iClk);
    iFlag = 1'b0;
    repeat (gap) @(negedge iClk);
  endtask

  task automatic checkOutput(input exp_t e);
    check("event_make", 32'(oMake), 32'(e.make));
    check("event_ext", 32'(oExt), 32'(e.ext));
    check("event_code", 32'(oCode), 32'(e.code));
    check("event_keys", 32'(oKeys), 32'(e.keys));
    check("event_note", 32'(oNote), 32'(lowestNote(e.keys)));
    check("event_notevalid", 32'(oNoteValid), 32'(|e.keys));
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_valid"}, 32'(oValid), 32'd0);
    check({tag, "_make"}, 32'(oMake), 32'd0);
    check({tag, "_ext"}, 32'(oExt), 32'd0);
    check({tag, "_code"}, 32'(oCode), 32'd0);
    check({tag, "_keys"}, 32'(oKeys), 32'd0);
    check({tag, "_notevalid"}, 32'(oNoteValid), 32'd0);
  endtask

  // Reset lands mid-cycle so its effect is seen without a clock edge.
  task automatic doReset();
    check("queue_empty_before_reset", 32'(expQ.size()), 32'd0);
    #2 iReset = 1'b1;
    #1 checkResetState("async_reset");
    @(negedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    mBrk  = 1'b0;
    mExt  = 1'b0;
    mKeys = '0;
  endtask

  always @(negedge iClk) begin
    if (!iReset && oValid) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_event: got oValid=1 code=%0h expected no event", oCode);
      end else begin
        popped = expQ.pop_front();
        checkOutput(popped);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    iReset = 1'b1;
    iFlag  = 1'b0;
    iData  = 8'h00;
    mBrk   = 1'b0;
    mExt   = 1'b0;
    mKeys  = '0;
    repeat (3) @(negedge iClk);
    checkResetState("reset");
    iReset = 1'b0;
    @(negedge iClk);

    applyStimulus(8'h1C, 1, 2);
    check("single_make_keys", 32'(oKeys), 32'h0001);
    applyStimulus(8'hF0, 1, 2);
    applyStimulus(8'h1C, 1, 2);
    check("single_break_keys", 32'(oKeys), 32'h0000);
    check("single_break_note", 32'(oNote), 32'd0);

    applyStimulus(8'h23, 1, 2);
    applyStimulus(8'h42, 1, 2);
    check("chord_keys", 32'(oKeys), 32'h1010);
    check("chord_note", 32'(oNote), 32'd4);
    applyStimulus(8'hF0, 1, 2);
    applyStimulus(8'h23, 1, 2);
    check("chord_release_keys", 32'(oKeys), 32'h1000);
    check("chord_release_note", 32'(oNote), 32'd12);
    check("chord_release_nv", 32'(oNoteValid), 32'd1);

    applyStimulus(8'hE0, 1, 2);
    applyStimulus(8'hF0, 1, 2);
    applyStimulus(8'h75, 1, 2);
    check("ext_break_code", 32'(oCode), 32'h75);
    check("ext_break_keys", 32'(oKeys), 32'h1000);

    applyStimulus(8'hF0, 1, TIMEOUT + 10);
    applyStimulus(8'h1C, 1, 2);
    check("timeout_make_bit0", 32'(oKeys[0]), 32'd1);
    applyStimulus(8'hF0, 1, TIMEOUT - 10);
    applyStimulus(8'h1C, 1, 2);
    check("slow_break_bit0", 32'(oKeys[0]), 32'd0);

    applyStimulus(8'h1B, 5, 2);
    applyStimulus(8'hAA, 1, 2);
    check("held_strobe_bit2", 32'(oKeys[2]), 32'd1);

    applyStimulus(8'hE0, 1, 2);
    doReset();
    applyStimulus(8'h1C, 1, 2);
    check("post_reset_keys", 32'(oKeys), 32'h0001);
    check("post_reset_ext", 32'(oExt), 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      int gap;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: b = noteCodes[$urandom_range(0, 12)];
        4:          b = 8'hE0;
        5, 6:       b = 8'hF0;
        7:          b = discardCodes[$urandom_range(0, 6)];
        default:    b = 8'($urandom_range(0, 255));
      endcase
      gap = ($urandom_range(0, 19) == 0) ? TIMEOUT + 10 : int'($urandom_range(1, 6));
      applyStimulus(b, int'($urandom_range(1, 4)), gap);
      if ($urandom_range(0, 59) == 0) doReset();
    end

    repeat (5) @(negedge iClk);
    check("queue_drained", 32'(expQ.size()), 32'd0);
    check("final_keys", 32'(oKeys), 32'(mKeys));
    check("final_note", 32'(oNote), 32'(lowestNote(mKeys)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
